// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI constants, encodings, FSM state and captured-request payload
// for the single-port SRAM AXI slave.
package axi_sram_slave_pkg;

   localparam int unsigned AXI_ID_W   = 8;
   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_LEN_W  = 4;
   localparam int unsigned AXI_SIZE_W = 3;
   localparam int unsigned AXI_STRB_W = 4;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      IDLE,
      R_ISSUE,
      R_WAIT,
      R_DATA,
      W_DATA,
      B_RESP
   } state_e;

   // Fields latched from the accepted AW or AR request
   typedef struct packed {
      logic [AXI_ID_W-1:0]  id;
      logic [AXI_LEN_W-1:0] len;
      burst_e               burst;
   } req_t;

   // Byte strobes (active-high) to SRAM bit write enables (active-low)
   function automatic logic [AXI_DATA_W-1:0] strb_to_bweb(input logic [AXI_STRB_W-1:0] strb);
      logic [AXI_DATA_W-1:0] bweb;
      for (int j = 0; j < int'(AXI_STRB_W); j++) begin
         bweb[8*j +: 8] = {8{~strb[j]}};
      end
      return bweb;
   endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 five-channel bundle between a master and the SRAM slave.
interface axi_sram_slave_if;
   import axi_sram_slave_pkg::*;

   logic [AXI_ID_W-1:0]   AWID;
   logic [AXI_ADDR_W-1:0] AWADDR;
   logic [AXI_LEN_W-1:0]  AWLEN;
   logic [AXI_SIZE_W-1:0] AWSIZE;
   logic [1:0]            AWBURST;
   logic                  AWVALID;
   logic                  AWREADY;

   logic [AXI_DATA_W-1:0] WDATA;
   logic [AXI_STRB_W-1:0] WSTRB;
   logic                  WLAST;
   logic                  WVALID;
   logic                  WREADY;

   logic [AXI_ID_W-1:0]   BID;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;

   logic [AXI_ID_W-1:0]   ARID;
   logic [AXI_ADDR_W-1:0] ARADDR;
   logic [AXI_LEN_W-1:0]  ARLEN;
   logic [AXI_SIZE_W-1:0] ARSIZE;
   logic [1:0]            ARBURST;
   logic                  ARVALID;
   logic                  ARREADY;

   logic [AXI_ID_W-1:0]   RID;
   logic [AXI_DATA_W-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY
   );

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY
   );

endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave fronting a single-port synchronous SRAM: one burst at a time,
// writes pass straight through, reads take issue/wait/data cycles per beat.
module axi_sram_slave
   import axi_sram_slave_pkg::*;
#(
   parameter int unsigned ADDR_W = 14
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   axi_sram_slave_if.slave       bus,
   output logic                  CEB,
   output logic                  WEB,
   output logic [AXI_DATA_W-1:0] BWEB,
   output logic [ADDR_W-1:0]     A,
   output logic [AXI_DATA_W-1:0] DI,
   input  logic [AXI_DATA_W-1:0] DO
);

   state_e                state_q, state_d;
   req_t                  req_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [AXI_LEN_W-1:0]  beat_q;
   logic [AXI_DATA_W-1:0] rdata_q;

   logic                  aw_hs_c, ar_hs_c, w_hs_c, r_hs_c, r_last_c;
   logic [ADDR_W-1:0]     addr_next_c;

   // Size and out-of-range address bits carry no meaning for 32-bit word SRAM
   logic unused_bits;
   assign unused_bits = ^{bus.AWSIZE, bus.ARSIZE, bus.AWADDR, bus.ARADDR};

   assign aw_hs_c     = (state_q == IDLE) && bus.AWVALID;
   assign ar_hs_c     = (state_q == IDLE) && !bus.AWVALID && bus.ARVALID;
   assign w_hs_c      = (state_q == W_DATA) && bus.WVALID;
   assign r_hs_c      = (state_q == R_DATA) && bus.RREADY;
   assign r_last_c    = (beat_q == req_q.len);
   assign addr_next_c = (req_q.burst == BURST_FIXED) ? addr_q : addr_q + ADDR_W'(1);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (aw_hs_c)      state_d = W_DATA;
            else if (ar_hs_c) state_d = R_ISSUE;
         end
         W_DATA:  if (w_hs_c && bus.WLAST) state_d = B_RESP;
         B_RESP:  if (bus.BREADY) state_d = IDLE;
         R_ISSUE: state_d = R_WAIT;
         R_WAIT:  state_d = R_DATA;
         R_DATA:  if (r_hs_c) state_d = r_last_c ? IDLE : R_ISSUE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture, beat/address stepping and read-data capture
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         req_q   <= '0;
         addr_q  <= '0;
         beat_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (aw_hs_c) begin
            req_q   <= '{id: bus.AWID, len: bus.AWLEN, burst: burst_e'(bus.AWBURST)};
            addr_q  <= bus.AWADDR[ADDR_W+1:2];
            beat_q  <= '0;
         end else if (ar_hs_c) begin
            req_q   <= '{id: bus.ARID, len: bus.ARLEN, burst: burst_e'(bus.ARBURST)};
            addr_q  <= bus.ARADDR[ADDR_W+1:2];
            beat_q  <= '0;
         end else if (w_hs_c || (r_hs_c && !r_last_c)) begin
            addr_q  <= addr_next_c;
            beat_q  <= beat_q + AXI_LEN_W'(1);
         end
         if (state_q == R_WAIT) rdata_q <= DO;
      end
   end

   always_comb begin
      bus.AWREADY = 1'b0;
      bus.ARREADY = 1'b0;
      bus.WREADY  = 1'b0;
      bus.BVALID  = 1'b0;
      bus.BID     = '0;
      bus.BRESP   = RESP_OKAY;
      bus.RVALID  = 1'b0;
      bus.RDATA   = '0;
      bus.RID     = '0;
      bus.RRESP   = RESP_OKAY;
      bus.RLAST   = 1'b0;
      CEB         = 1'b1;
      WEB         = 1'b1;
      BWEB        = '1;
      A           = '0;
      DI          = '0;
      case (state_q)
         IDLE: begin
            bus.AWREADY = 1'b1;
            bus.ARREADY = !bus.AWVALID;
         end
         W_DATA: begin
            bus.WREADY = 1'b1;
            if (bus.WVALID) begin
               CEB  = 1'b0;
               WEB  = 1'b0;
               A    = addr_q;
               DI   = bus.WDATA;
               BWEB = strb_to_bweb(bus.WSTRB);
            end
         end
         B_RESP: begin
            bus.BVALID = 1'b1;
            bus.BID    = req_q.id;
         end
         R_ISSUE: begin
            CEB = 1'b0;
            A   = addr_q;
         end
         R_DATA: begin
            bus.RVALID = 1'b1;
            bus.RDATA  = rdata_q;
            bus.RID    = req_q.id;
            bus.RLAST  = r_last_c;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: drivers queue expected SRAM accesses and
// B/R responses; a negedge monitor pops and compares them as the DUT shows them.
module tb_axi_sram_slave;
   import axi_sram_slave_pkg::*;

   localparam int unsigned AW = 14;

   logic            ACLK = 1'b0;
   logic            ARESET;
   logic            CEB, WEB;
   logic [31:0]     BWEB, DI, DO;
   logic [AW-1:0]   A;

   axi_sram_slave_if bus ();

   axi_sram_slave #(.ADDR_W(AW)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus),
      .CEB    (CEB),
      .WEB    (WEB),
      .BWEB   (BWEB),
      .A      (A),
      .DI     (DI),
      .DO     (DO)
   );

   always #5 ACLK = ~ACLK;

   // Behavioural SRAM: byte-masked write, read data one cycle after access
   logic [31:0] mem [0:(1<<AW)-1];
   always @(posedge ACLK) begin
      if (!CEB) begin
         if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
         else      DO     <= mem[A];
      end
   end

   typedef struct packed { logic [AW-1:0] a; logic [31:0] di; logic [31:0] bweb; } wexp_t;
   typedef struct packed { logic [7:0] id; logic [31:0] data; logic last; } rexp_t;
   typedef struct packed { logic [7:0] id; logic [1:0] resp; } bexp_t;

   wexp_t         q_w  [$];
   logic [AW-1:0] q_ra [$];
   rexp_t         q_r  [$];
   bexp_t         q_b  [$];

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] rd [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event seen with nothing expected", name);
   endtask

   function automatic logic [31:0] exp_bweb(input logic [3:0] s);
      logic [31:0] b;
      for (int j = 0; j < 4; j++) b[8*j +: 8] = s[j] ? 8'h00 : 8'hFF;
      return b;
   endfunction

   // Scoreboard monitor
   wexp_t         mw;
   rexp_t         mr;
   bexp_t         mb;
   logic [AW-1:0] ma;
   always @(negedge ACLK) begin
      if (!ARESET) begin
         if (CEB == 1'b0 && WEB == 1'b0) begin
            if (q_w.size() == 0) unexpected("sram_write");
            else begin
               mw = q_w.pop_front();
               chk("sram_wr_addr", 32'(A), 32'(mw.a));
               chk("sram_wr_data", DI, mw.di);
               chk("sram_wr_bweb", BWEB, mw.bweb);
            end
         end
         if (CEB == 1'b0 && WEB == 1'b1) begin
            if (q_ra.size() == 0) unexpected("sram_read");
            else begin
               ma = q_ra.pop_front();
               chk("sram_rd_addr", 32'(A), 32'(ma));
            end
         end
         if (bus.BVALID) begin
            if (q_b.size() == 0) unexpected("b_resp");
            else begin
               mb = q_b[0];
               chk("bid", 32'(bus.BID), 32'(mb.id));
               chk("bresp", 32'(bus.BRESP), 32'(mb.resp));
               if (bus.BREADY) void'(q_b.pop_front());
            end
         end
         if (bus.RVALID) begin
            if (q_r.size() == 0) unexpected("r_beat");
            else begin
               mr = q_r[0];
               chk("rid", 32'(bus.RID), 32'(mr.id));
               chk("rdata", bus.RDATA, mr.data);
               chk("rresp", 32'(bus.RRESP), 32'd0);
               chk("rlast", 32'(bus.RLAST), 32'(mr.last));
               if (bus.RREADY) void'(q_r.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return bus.AWREADY;
         1:       return bus.ARREADY;
         2:       return bus.WREADY;
         3:       return bus.BVALID;
         default: return bus.RVALID;
      endcase
   endfunction

   // Returns on the negedge where the selected signal is high (bounded)
   task automatic wait_hi(input int which, input string name);
      int n = 0;
      @(negedge ACLK);
      while (!sig(which) && n < 40) begin
         @(negedge ACLK);
         n++;
      end
      if (!sig(which)) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: actual=0 required=1", name);
      end
   endtask

   task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
      bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWBURST = burst;
      bus.AWSIZE = 3'd2; bus.AWVALID = 1'b1;
      wait_hi(0, "awready");
      tick();
      bus.AWVALID = 1'b0;
   endtask

   task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
      bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARBURST = burst;
      bus.ARSIZE = 3'd2; bus.ARVALID = 1'b1;
      wait_hi(1, "arready");
      tick();
      bus.ARVALID = 1'b0;
   endtask

   task automatic w_beat(input logic [AW-1:0] word, input logic [31:0] data,
                         input logic [3:0] strb, input logic last);
      q_w.push_back('{a: word, di: data, bweb: exp_bweb(strb)});
      bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
      wait_hi(2, "wready");
      tick();
      bus.WVALID = 1'b0;
      bus.WLAST  = 1'b0;
   endtask

   task automatic b_phase(input logic [7:0] id, input int delay);
      q_b.push_back('{id: id, resp: 2'b00});
      @(negedge ACLK);
      chk("b_latency", 32'(bus.BVALID), 32'd1);
      repeat (delay + 1) tick();
      bus.BREADY = 1'b1;
      wait_hi(3, "bvalid");
      tick();
      bus.BREADY = 1'b0;
   endtask

   task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input int bdelay);
      logic [AW-1:0] word = addr[AW+1:2];
      aw_phase(id, addr, len, burst);
      for (int i = 0; i <= int'(len); i++) begin
         w_beat(word, wd[i], ws[i], i == int'(len));
         if (burst != 2'b00) word = word + AW'(1);
      end
      b_phase(id, bdelay);
   endtask

   task automatic r_collect(input logic [3:0] len, input int stall0);
      for (int i = 0; i <= int'(len); i++) begin
         wait_hi(4, "rvalid");
         repeat ((i == 0 ? stall0 : 0) + 1) tick();
         bus.RREADY = 1'b1;
         @(negedge ACLK);
         tick();
         bus.RREADY = 1'b0;
      end
   endtask

   task automatic push_read(input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst);
      logic [AW-1:0] word = addr[AW+1:2];
      for (int i = 0; i <= int'(len); i++) begin
         q_ra.push_back(word);
         q_r.push_back('{id: id, data: rd[i], last: (i == int'(len))});
         if (burst != 2'b00) word = word + AW'(1);
      end
   endtask

   task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input int stall0);
      push_read(id, addr, len, burst);
      ar_phase(id, addr, len, burst);
      r_collect(len, stall0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ARESET = 1'b1;
      bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
      bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("rst_ceb", 32'(CEB), 32'd1);
      chk("rst_web", 32'(WEB), 32'd1);
      chk("rst_bweb", BWEB, 32'hFFFF_FFFF);
      chk("rst_a", 32'(A), 32'd0);
      chk("rst_bvalid", 32'(bus.BVALID), 32'd0);
      chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
      chk("rst_rlast", 32'(bus.RLAST), 32'd0);
      chk("rst_awready", 32'(bus.AWREADY), 32'd1);
      chk("rst_arready", 32'(bus.ARREADY), 32'd1);
      chk("rst_wready", 32'(bus.WREADY), 32'd0);
      tick();
      ARESET = 1'b0;
      tick();

      // 4-beat INCR write at word 4..7, BREADY delayed two cycles
      wd[0] = 32'h0123_4567; wd[1] = 32'h89AB_CDEF; wd[2] = 32'hDEAD_BEEF; wd[3] = 32'h0BAD_F00D;
      for (int i = 0; i < 4; i++) ws[i] = 4'hF;
      write_burst(8'h5A, 32'h10, 4'd3, 2'b01, 2);

      // Full write then partial-strobe overwrite of word 0x20
      wd[0] = 32'h1122_3344; ws[0] = 4'hF;
      write_burst(8'h01, 32'h80, 4'd0, 2'b01, 0);
      wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
      write_burst(8'h02, 32'h80, 4'd0, 2'b01, 0);

      // Read back the 4-beat burst with a 5-cycle stall on beat 0
      rd[0] = 32'h0123_4567; rd[1] = 32'h89AB_CDEF; rd[2] = 32'hDEAD_BEEF; rd[3] = 32'h0BAD_F00D;
      read_burst(8'hC3, 32'h10, 4'd3, 2'b01, 5);

      rd[0] = 32'h11BB_33DD;
      read_burst(8'h07, 32'h80, 4'd0, 2'b01, 0);

      // AW and AR together: write first, read after B handshake
      q_w.push_back('{a: AW'(14'h10), di: 32'h5555_AAAA, bweb: 32'h0});
      rd[0] = 32'h5555_AAAA;
      push_read(8'h44, 32'h40, 4'd0, 2'b01);
      bus.AWID = 8'h33; bus.AWADDR = 32'h40; bus.AWLEN = 4'd0; bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
      bus.ARID = 8'h44; bus.ARADDR = 32'h40; bus.ARLEN = 4'd0; bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
      @(negedge ACLK);
      chk("both_awready", 32'(bus.AWREADY), 32'd1);
      chk("both_arready", 32'(bus.ARREADY), 32'd0);
      tick();
      bus.AWVALID = 1'b0;
      @(negedge ACLK);
      chk("busy_arready", 32'(bus.ARREADY), 32'd0);
      tick();
      bus.WDATA = 32'h5555_AAAA; bus.WSTRB = 4'hF; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
      wait_hi(2, "wready");
      tick();
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
      b_phase(8'h33, 0);
      wait_hi(1, "arready");
      tick();
      bus.ARVALID = 1'b0;
      r_collect(4'd0, 0);

      // INCR write across the top of the word space wraps to 0
      wd[0] = 32'hCAFE_F00D; wd[1] = 32'h600D_D00D; ws[0] = 4'hF; ws[1] = 4'hF;
      write_burst(8'h10, 32'h0000_FFFC, 4'd1, 2'b01, 0);

      // FIXED read at the top word repeats the same address
      rd[0] = 32'hCAFE_F00D; rd[1] = 32'hCAFE_F00D; rd[2] = 32'hCAFE_F00D;
      read_burst(8'h99, 32'h0000_FFFC, 4'd2, 2'b00, 0);

      rd[0] = 32'hCAFE_F00D; rd[1] = 32'h600D_D00D;
      read_burst(8'h9A, 32'h0000_FFFC, 4'd1, 2'b01, 0);

      // Reset during beat 2 of a 4-beat write
      aw_phase(8'h77, 32'h10, 4'd3, 2'b01);
      w_beat(AW'(14'd4), 32'hA0A0_0000, 4'hF, 1'b0);
      w_beat(AW'(14'd5), 32'hA0A0_0001, 4'hF, 1'b0);
      bus.WDATA = 32'hA0A0_0002; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      ARESET = 1'b1;
      @(negedge ACLK);
      chk("midrst_ceb", 32'(CEB), 32'd1);
      chk("midrst_bvalid", 32'(bus.BVALID), 32'd0);
      chk("midrst_awready", 32'(bus.AWREADY), 32'd1);
      chk("midrst_wready", 32'(bus.WREADY), 32'd0);
      tick();
      bus.WVALID = 1'b0;
      ARESET = 1'b0;
      repeat (10) tick();
      chk("post_rst_bvalid", 32'(bus.BVALID), 32'd0);

      // Beats before the reset landed; beat 2 did not
      rd[0] = 32'hA0A0_0000; rd[1] = 32'hA0A0_0001; rd[2] = 32'hDEAD_BEEF;
      read_burst(8'h78, 32'h10, 4'd2, 2'b01, 0);

      repeat (4) tick();
      chk("left_w", 32'(q_w.size()), 32'd0);
      chk("left_ra", 32'(q_ra.size()), 32'd0);
      chk("left_b", 32'(q_b.size()), 32'd0);
      chk("left_r", 32'(q_r.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning SRAM word-address width.
REQ-002 SHALL have port ACLK  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port ARESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have AW ports: AWID in 8, AWADDR in 32, AWLEN in 4, AWSIZE in 3, AWBURST in 2, AWVALID in 1, AWREADY out 1.
REQ-005 SHALL have W ports: WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1, WREADY out 1.
REQ-006 SHALL have B ports: BID out 8, BRESP out 2, BVALID out 1, BREADY in 1.
REQ-007 SHALL have AR ports: ARID in 8, ARADDR in 32, ARLEN in 4, ARSIZE in 3, ARBURST in 2, ARVALID in 1, ARREADY out 1.
REQ-008 SHALL have R ports: RID out 8, RDATA out 32, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1.
REQ-009 SHALL have SRAM ports: CEB out 1 (chip enable, active-low), WEB out 1 (write enable, active-low), BWEB out 32 (bit write enable, active-low), A out ADDR_W, DI out 32, DO in 32 (valid one cycle after a read access).

Function
REQ-010 SHALL implement FSM states IDLE, R_ISSUE, R_WAIT, R_DATA, W_DATA, B_RESP.
REQ-011 In IDLE: AWREADY=1; ARREADY = !AWVALID (write wins when both valid); all other AXI handshake outputs 0.
REQ-012 AW handshake SHALL capture AWID, word address AWADDR[ADDR_W+1:2], AWLEN, AWBURST; beat counter cleared; next W_DATA.
REQ-013 AR handshake SHALL capture the same AR fields; next R_ISSUE.
REQ-014 W_DATA: WREADY=1; each WVALID&&WREADY SHALL, same cycle, drive CEB=0, WEB=0, A=current address, DI=WDATA, BWEB bit-byte j = ~WSTRB[j] (8 bits each).
REQ-015 W beat with WLAST=1 SHALL move to B_RESP; WLAST is authoritative, beat count is not checked against AWLEN.
REQ-016 B_RESP: BVALID=1, BID=captured ID, BRESP=2'b00, held stable until BREADY; then IDLE.
REQ-017 R_ISSUE: CEB=0, WEB=1, A=current address, for exactly one cycle; next R_WAIT.
REQ-018 R_WAIT: DO SHALL be registered into read-data register; next R_DATA.
REQ-019 R_DATA: RVALID=1, RDATA=registered data, RID=captured ID, RRESP=2'b00, RLAST = (beat count == ARLEN); all held stable until RREADY.
REQ-020 R handshake with RLAST=1 SHALL move to IDLE; otherwise increment beat count and address, move to R_ISSUE (3 cycles/beat minimum).
REQ-021 Address SHALL increment by 1 per beat for AxBURST INCR (2'b01) and WRAP (2'b10, treated as INCR); hold for FIXED (2'b00); wrap modulo 2^ADDR_W.
REQ-022 Outside REQ-014/REQ-017: CEB=1, WEB=1, BWEB all-ones, A=0, DI=0.
REQ-023 AxSIZE SHALL be ignored (32-bit beats only); ADDR bits [1:0] and above ADDR_W+1 ignored.
REQ-024 At most one transaction outstanding; AWREADY/ARREADY SHALL be 0 outside IDLE.

Reset
REQ-025 ARESET assertion SHALL immediately force IDLE, clear all registers, and force CEB=1, WEB=1, BWEB all-ones, BVALID=0, RVALID=0, RLAST=0; ARREADY=1 and AWREADY=1 combinationally from IDLE per REQ-011.
REQ-026 Reset mid-burst SHALL abandon the burst with no further SRAM access and no B or R response.

Structure
REQ-027 AXI width constants (ID 8 slave-side, ADDR 32, DATA 32, LEN 4, SIZE 3, STRB 4), BURST/RESP encodings and the FSM state enum SHALL live in the shared AXI package.
REQ-028 Single module; no sub-module required.

Verification
REQ-029 AWADDR=0x10, AWLEN=3, 4 beats WSTRB=4'hF -> SRAM writes at A=4,5,6,7; BVALID one cycle after last W beat, BID=AWID, BRESP=0.
REQ-030 Write WSTRB=4'b0101 -> BWEB=0xFF00FF00 on that beat.
REQ-031 After REQ-029, ARADDR=0x10, ARLEN=3, RREADY held low 5 cycles on beat 0 -> RDATA stable; 4 beats returned in order; RLAST only on beat 4.
REQ-032 ARVALID and AWVALID asserted same IDLE cycle -> AWREADY=1, ARREADY=0; read serviced after B handshake.
REQ-033 FIXED read burst ARLEN=2 at max word address -> A constant; INCR at A=2^ADDR_W-1 -> next A=0.
REQ-034 ARESET pulsed during beat 2 of 4-beat write -> IDLE, no further CEB=0, BVALID stays 0.
